// File: rtl/r3_vec_addsub_if.sv
// Beat-stream bundle for r3_vec_addsub: input beat, per-beat op and scalar, result beat and status.
// master drives the input side and o_ready; slave is the vector unit.
interface r3_vec_addsub_if #(
  parameter int P  = 16,
  parameter int CW = 6
);
  logic           i_clear;
  logic           i_valid;
  logic           i_ready;
  logic [1:0]     i_op;
  logic [1:0]     i_scale;
  logic [2*P-1:0] i_f;
  logic [2*P-1:0] i_g;
  logic           o_valid;
  logic           o_ready;
  logic [2*P-1:0] o_c;
  logic           o_last;
  logic [CW-1:0]  o_beat;
  logic           o_err;

  modport master (
    output i_clear, i_valid, i_op, i_scale, i_f, i_g, o_ready,
    input  i_ready, o_valid, o_c, o_last, o_beat, o_err
  );

  modport slave (
    input  i_clear, i_valid, i_op, i_scale, i_f, i_g, o_ready,
    output i_ready, o_valid, o_c, o_last, o_beat, o_err
  );
endinterface

// File: rtl/r3_vec_addsub.sv
// P-lane Z/3 streaming c = f + s*g with beat tracking and last-beat padding; illegal-code check under R3_ILLEGAL_CHK_EN.
// Latency: one register stage, full throughput of one beat per cycle.
// Backpressure: i_ready = !o_valid | o_ready, so a stalled result holds and blocks new beats.
module r3_vec_addsub #(
  parameter int P   = 16,
  parameter int LEN = 761
) (
  input  logic             clk,
  input  logic             rst_n,
  r3_vec_addsub_if.slave   bus
);
  localparam int BEATS  = (LEN + P - 1) / P;
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PAD_LO = LEN - (BEATS - 1) * P;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_SCALE = 2'b10;

  // Negation in this encoding swaps 01 and 11 and leaves 00 alone.
  function automatic logic [1:0] t_neg(input logic [1:0] x);
    return {x[0] & ~x[1], x[0]};
  endfunction

  function automatic logic [1:0] t_mul(input logic [1:0] s, input logic [1:0] x);
    case (s)
      2'b01:   return x;
      2'b11:   return t_neg(x);
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] t_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] sum;
    sum = {a[1], a} + {b[1], b};
    case (sum)
      3'b001, 3'b110: return 2'b01;  // +1 and -2
      3'b111, 3'b010: return 2'b11;  // -1 and +2
      default:        return 2'b00;
    endcase
  endfunction

  logic           o_valid_q;
  logic [2*P-1:0] o_c_q;
  logic           o_last_q;
  logic [CW-1:0]  o_beat_q;
  logic [CW-1:0]  cnt;
  logic [1:0]     s;
  logic [2*P-1:0] res;
  logic           lane_bad;
  logic [1:0]     lane_f;
  logic [1:0]     lane_g;
  logic [1:0]     lane_r;
  logic           lane_pad;
  logic           i_ready_w;
  logic           accept;

  assign i_ready_w = !o_valid_q || bus.o_ready;
  assign accept    = bus.i_valid && i_ready_w && !bus.i_clear;

  always_comb begin
    case (bus.i_op)
      OP_ADD:   s = 2'b01;
      OP_SUB:   s = 2'b11;
      OP_SCALE: s = bus.i_scale;
      default:  s = 2'b00;
    endcase
  end

  always_comb begin
    res      = '0;
    lane_bad = 1'b0;
    lane_f   = 2'b00;
    lane_g   = 2'b00;
    lane_r   = 2'b00;
    lane_pad = 1'b0;
    for (int k = 0; k < P; k++) begin
      lane_f   = bus.i_f[2*k +: 2];
      lane_g   = bus.i_g[2*k +: 2];
      lane_pad = (cnt == LAST_BEAT) && (k >= PAD_LO);
      lane_r   = t_add(lane_f, t_mul(s, lane_g));
`ifdef R3_ILLEGAL_CHK_EN
      if (!lane_pad && ((lane_f == 2'b10) || (lane_g == 2'b10) ||
                        ((bus.i_op == OP_SCALE) && (bus.i_scale == 2'b10)))) begin
        lane_r   = 2'b00;
        lane_bad = 1'b1;
      end
`endif
      if (lane_pad) lane_r = 2'b00;
      res[2*k +: 2] = lane_r;
    end
  end

  // Output stage loads only on accept, so idle X inputs never reach state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q <= 1'b0;
      o_c_q     <= '0;
      o_last_q  <= 1'b0;
      o_beat_q  <= '0;
      cnt       <= '0;
    end else if (bus.i_clear) begin
      o_valid_q <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      o_valid_q <= 1'b1;
      o_c_q     <= res;
      o_last_q  <= (cnt == LAST_BEAT);
      o_beat_q  <= cnt;
      cnt       <= (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
    end else if (bus.o_ready) begin
      o_valid_q <= 1'b0;
    end
  end

`ifdef R3_ILLEGAL_CHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    err_q <= 1'b0;
    else if (accept && lane_bad)   err_q <= 1'b1;
  end
  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
  logic unused_bad;
  assign unused_bad = lane_bad;
`endif

  assign bus.i_ready = i_ready_w;
  assign bus.o_valid = o_valid_q;
  assign bus.o_c     = o_c_q;
  assign bus.o_last  = o_last_q;
  assign bus.o_beat  = o_beat_q;
endmodule
